wb_arbiter2: RTL and testbench



---
 rtl/wb_arbiter2.sv | 206 ++++++++++++++++++++
 tb/tb_wb_arbiter2.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master Wishbone arbiter, round-robin, cyc-locked grant, bus watchdog
module wb_arbiter2 #(
   parameter int addr_width     = 32,
   parameter int data_width     = 32,
   parameter int strobe_width   = data_width / 8,
   parameter int timeout_cycles = 255
) (
   input  logic                    clock,
   input  logic                    reset,

   input  logic [addr_width-1:0]   m0_wb_adr,
   input  logic [data_width-1:0]   m0_wb_datwr,
   input  logic [strobe_width-1:0] m0_wb_sel,
   input  logic                    m0_wb_we,
   input  logic                    m0_wb_stb,
   input  logic                    m0_wb_cyc,
   output logic [data_width-1:0]   m0_wb_datrd,
   output logic                    m0_wb_ack,

   input  logic [addr_width-1:0]   m1_wb_adr,
   input  logic [data_width-1:0]   m1_wb_datwr,
   input  logic [strobe_width-1:0] m1_wb_sel,
   input  logic                    m1_wb_we,
   input  logic                    m1_wb_stb,
   input  logic                    m1_wb_cyc,
   output logic [data_width-1:0]   m1_wb_datrd,
   output logic                    m1_wb_ack,

   output logic [addr_width-1:0]   s_wb_adr,
   output logic [data_width-1:0]   s_wb_datwr,
   output logic [strobe_width-1:0] s_wb_sel,
   output logic                    s_wb_we,
   output logic                    s_wb_stb,
   output logic                    s_wb_cyc,
   input  logic [data_width-1:0]   s_wb_datrd,
   input  logic                    s_wb_ack,

   output logic [1:0]              grant
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam bit wd_enable = (timeout_cycles > 0);
   localparam int cnt_width = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
   localparam logic [cnt_width-1:0] wd_limit = cnt_width'(timeout_cycles);

   state_t                 state_q;
   state_t                 state_d;
   logic                   last_grant_q;
   logic                   last_grant_d;
   logic [cnt_width-1:0]   wd_cnt_q;
   logic [cnt_width-1:0]   wd_cnt_d;

   logic                    owned;
   logic [addr_width-1:0]   own_adr;
   logic [data_width-1:0]   own_datwr;
   logic [strobe_width-1:0] own_sel;
   logic                    own_we;
   logic                    own_stb;
   logic                    own_cyc;

   logic                    wd_fire;
   logic                    slave_stb;
   logic                    slave_cyc;
   logic                    ack_fwd;
   logic                    bus_ack;
   logic [data_width-1:0]   bus_datrd;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         wd_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         wd_cnt_q     <= wd_cnt_d;
      end
   end

   // Next-state: a tie goes to the master that did not own the bus last
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (m0_wb_cyc && m1_wb_cyc) begin
               if (last_grant_q) begin
                  state_d      = OWN0;
                  last_grant_d = 1'b0;
               end else begin
                  state_d      = OWN1;
                  last_grant_d = 1'b1;
               end
            end else if (m0_wb_cyc) begin
               state_d      = OWN0;
               last_grant_d = 1'b0;
            end else if (m1_wb_cyc) begin
               state_d      = OWN1;
               last_grant_d = 1'b1;
            end
         end
         OWN0: begin
            if (!m0_wb_cyc) state_d = IDLE;
         end
         OWN1: begin
            if (!m1_wb_cyc) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Owner select: the bus follows whichever master holds the grant
   always_comb begin
      owned     = 1'b0;
      own_adr   = '0;
      own_datwr = '0;
      own_sel   = '0;
      own_we    = 1'b0;
      own_stb   = 1'b0;
      own_cyc   = 1'b0;
      case (state_q)
         OWN0: begin
            owned     = 1'b1;
            own_adr   = m0_wb_adr;
            own_datwr = m0_wb_datwr;
            own_sel   = m0_wb_sel;
            own_we    = m0_wb_we;
            own_stb   = m0_wb_stb & m0_wb_cyc;
            own_cyc   = m0_wb_cyc;
         end
         OWN1: begin
            owned     = 1'b1;
            own_adr   = m1_wb_adr;
            own_datwr = m1_wb_datwr;
            own_sel   = m1_wb_sel;
            own_we    = m1_wb_we;
            own_stb   = m1_wb_stb & m1_wb_cyc;
            own_cyc   = m1_wb_cyc;
         end
         default: ;
      endcase
   end

   // Watchdog terminates the access in place of the slave and drops the slave cycle for that beat
   assign wd_fire   = wd_enable && owned && own_stb && (wd_cnt_q == wd_limit);
   assign slave_stb = own_stb & ~wd_fire;
   assign slave_cyc = own_cyc & ~wd_fire;
   assign ack_fwd   = s_wb_ack & slave_stb;
   assign bus_ack   = ack_fwd | wd_fire;
   assign bus_datrd = wd_fire ? {data_width{1'b1}} : s_wb_datrd;

   always_comb begin
      if (!wd_enable || !owned || !own_stb || s_wb_ack || wd_fire) begin
         wd_cnt_d = '0;
      end else begin
         wd_cnt_d = wd_cnt_q + cnt_width'(1);
      end
   end

   // Outputs: IDLE drives everything to zero; the non-owner never sees ack or data
   always_comb begin
      s_wb_adr    = '0;
      s_wb_datwr  = '0;
      s_wb_sel    = '0;
      s_wb_we     = 1'b0;
      s_wb_stb    = 1'b0;
      s_wb_cyc    = 1'b0;
      m0_wb_ack   = 1'b0;
      m0_wb_datrd = '0;
      m1_wb_ack   = 1'b0;
      m1_wb_datrd = '0;
      grant       = 2'b00;
      case (state_q)
         OWN0: begin
            s_wb_adr    = own_adr;
            s_wb_datwr  = own_datwr;
            s_wb_sel    = own_sel;
            s_wb_we     = own_we;
            s_wb_stb    = slave_stb;
            s_wb_cyc    = slave_cyc;
            m0_wb_ack   = bus_ack;
            m0_wb_datrd = bus_datrd;
            grant       = 2'b01;
         end
         OWN1: begin
            s_wb_adr    = own_adr;
            s_wb_datwr  = own_datwr;
            s_wb_sel    = own_sel;
            s_wb_we     = own_we;
            s_wb_stb    = slave_stb;
            s_wb_cyc    = slave_cyc;
            m1_wb_ack   = bus_ack;
            m1_wb_datrd = bus_datrd;
            grant       = 2'b10;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - scoreboard bench for wb_arbiter2
module tb_wb_arbiter2;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] m0_wb_adr, m0_wb_datwr, m0_wb_datrd;
   logic [3:0]  m0_wb_sel;
   logic        m0_wb_we, m0_wb_stb, m0_wb_cyc, m0_wb_ack;
   logic [31:0] m1_wb_adr, m1_wb_datwr, m1_wb_datrd;
   logic [3:0]  m1_wb_sel;
   logic        m1_wb_we, m1_wb_stb, m1_wb_cyc, m1_wb_ack;
   logic [31:0] s_wb_adr, s_wb_datwr, s_wb_datrd;
   logic [3:0]  s_wb_sel;
   logic        s_wb_we, s_wb_stb, s_wb_cyc, s_wb_ack;
   logic [1:0]  grant;

   logic [31:0] d2_m0_datrd, d2_m1_datrd, d2_s_adr, d2_s_datwr;
   logic [3:0]  d2_s_sel;
   logic        d2_m0_ack, d2_m1_ack, d2_s_we, d2_s_stb, d2_s_cyc;
   logic [1:0]  d2_grant;

   int          checks = 0;
   int          passes = 0;
   int          slave_wait = 0;
   logic        slave_en = 1'b1;
   logic [31:0] rd_data = 32'h0BAD_F00D;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        we;
   } s_exp_t;

   typedef struct {
      int          m;
      logic [31:0] dat;
      logic        wd;
   } a_exp_t;

   s_exp_t sq[$];
   a_exp_t aq[$];

   always #5 clock = ~clock;

   wb_arbiter2 #(.timeout_cycles(4)) u_dut (
      .clock(clock), .reset(reset),
      .m0_wb_adr(m0_wb_adr), .m0_wb_datwr(m0_wb_datwr), .m0_wb_sel(m0_wb_sel),
      .m0_wb_we(m0_wb_we), .m0_wb_stb(m0_wb_stb), .m0_wb_cyc(m0_wb_cyc),
      .m0_wb_datrd(m0_wb_datrd), .m0_wb_ack(m0_wb_ack),
      .m1_wb_adr(m1_wb_adr), .m1_wb_datwr(m1_wb_datwr), .m1_wb_sel(m1_wb_sel),
      .m1_wb_we(m1_wb_we), .m1_wb_stb(m1_wb_stb), .m1_wb_cyc(m1_wb_cyc),
      .m1_wb_datrd(m1_wb_datrd), .m1_wb_ack(m1_wb_ack),
      .s_wb_adr(s_wb_adr), .s_wb_datwr(s_wb_datwr), .s_wb_sel(s_wb_sel),
      .s_wb_we(s_wb_we), .s_wb_stb(s_wb_stb), .s_wb_cyc(s_wb_cyc),
      .s_wb_datrd(s_wb_datrd), .s_wb_ack(s_wb_ack),
      .grant(grant)
   );

   wb_arbiter2 #(.timeout_cycles(0)) u_dut_nowd (
      .clock(clock), .reset(reset),
      .m0_wb_adr(m0_wb_adr), .m0_wb_datwr(m0_wb_datwr), .m0_wb_sel(m0_wb_sel),
      .m0_wb_we(m0_wb_we), .m0_wb_stb(m0_wb_stb), .m0_wb_cyc(m0_wb_cyc),
      .m0_wb_datrd(d2_m0_datrd), .m0_wb_ack(d2_m0_ack),
      .m1_wb_adr(m1_wb_adr), .m1_wb_datwr(m1_wb_datwr), .m1_wb_sel(m1_wb_sel),
      .m1_wb_we(m1_wb_we), .m1_wb_stb(m1_wb_stb), .m1_wb_cyc(m1_wb_cyc),
      .m1_wb_datrd(d2_m1_datrd), .m1_wb_ack(d2_m1_ack),
      .s_wb_adr(d2_s_adr), .s_wb_datwr(d2_s_datwr), .s_wb_sel(d2_s_sel),
      .s_wb_we(d2_s_we), .s_wb_stb(d2_s_stb), .s_wb_cyc(d2_s_cyc),
      .s_wb_datrd(s_wb_datrd), .s_wb_ack(s_wb_ack),
      .grant(d2_grant)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_s(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel, input logic we);
      s_exp_t e;
      e.adr = adr; e.dat = dat; e.sel = sel; e.we = we;
      sq.push_back(e);
   endtask

   task automatic push_a(input int m, input logic [31:0] dat, input logic wd);
      a_exp_t e;
      e.m = m; e.dat = dat; e.wd = wd;
      aq.push_back(e);
   endtask

   task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      if (m == 1) begin
         m1_wb_cyc = cyc; m1_wb_stb = stb; m1_wb_we = we;
         m1_wb_adr = adr; m1_wb_datwr = dat; m1_wb_sel = sel;
      end else begin
         m0_wb_cyc = cyc; m0_wb_stb = stb; m0_wb_we = we;
         m0_wb_adr = adr; m0_wb_datwr = dat; m0_wb_sel = sel;
      end
   endtask

   function automatic logic ack_of(input int m);
      return (m == 1) ? m1_wb_ack : m0_wb_ack;
   endfunction

   // One locked cycle of n transfers, then one cycle with cyc low before returning
   task automatic m_run(input int m, input int n, input logic we,
                        input logic [31:0] adr0, input logic [31:0] dat0, input logic [3:0] sel);
      int   budget;
      logic got;
      for (int i = 0; i < n; i++) begin
         drive(m, 1'b1, 1'b1, we, adr0 + 32'(4 * i), dat0 + 32'(i), sel);
         budget = 60;
         got    = 1'b0;
         while (!got && budget > 0) begin
            @(negedge clock);
            got = ack_of(m);
            if (!got) begin
               budget--;
               tick();
            end
         end
         chk($sformatf("ack_wait_m%0d", m), {31'b0, got}, 32'd1);
         tick();
      end
      drive(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
   endtask

   // Slave: acks after slave_wait stalled cycles; slave_wait < 0 never acks
   initial begin
      int ws;
      ws = 0;
      s_wb_ack = 1'b0;
      s_wb_datrd = rd_data;
      forever begin
         @(posedge clock);
         #2;
         if (slave_en) begin
            if (s_wb_cyc && s_wb_stb) begin
               if (ws == slave_wait) begin
                  s_wb_ack = 1'b1;
                  ws = 0;
               end else begin
                  s_wb_ack = 1'b0;
                  ws++;
               end
            end else begin
               s_wb_ack = 1'b0;
               ws = 0;
            end
         end
         s_wb_datrd = rd_data;
      end
   end

   // Monitor: slave-side accepted beats and master acks are popped against the scoreboard
   initial begin
      s_exp_t se;
      a_exp_t ae;
      forever begin
         @(negedge clock);
         if (s_wb_stb && s_wb_ack) begin
            chk("slave_beat_expected", {31'b0, sq.size() > 0}, 32'd1);
            if (sq.size() > 0) begin
               se = sq.pop_front();
               chk("slave_adr", s_wb_adr, se.adr);
               chk("slave_datwr", s_wb_datwr, se.dat);
               chk("slave_sel", {28'b0, s_wb_sel}, {28'b0, se.sel});
               chk("slave_we", {31'b0, s_wb_we}, {31'b0, se.we});
            end
         end
         if (m0_wb_ack || m1_wb_ack) begin
            chk("ack_expected", {31'b0, aq.size() > 0}, 32'd1);
            chk("ack_onehot", {31'b0, m0_wb_ack & m1_wb_ack}, 32'd0);
            if (aq.size() > 0) begin
               ae = aq.pop_front();
               chk("ack_owner", {31'b0, m1_wb_ack}, 32'(ae.m));
               chk("ack_datrd", (ae.m == 1) ? m1_wb_datrd : m0_wb_datrd, ae.dat);
               chk("ack_other_datrd", (ae.m == 1) ? m0_wb_datrd : m1_wb_datrd, 32'h0);
               chk("ack_grant", {30'b0, grant}, (ae.m == 1) ? 32'd2 : 32'd1);
               if (ae.wd) chk("wd_slave_cyc_stb", {30'b0, s_wb_cyc, s_wb_stb}, 32'd0);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      drive(0, 1'b1, 1'b1, 1'b1, 32'h1234, 32'h55, 4'hF);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (3) @(posedge clock);
      #1;
      @(negedge clock);
      chk("rst_grant", {30'b0, grant}, 32'd0);
      chk("rst_slave_ctl", {29'b0, s_wb_cyc, s_wb_stb, s_wb_we}, 32'd0);
      chk("rst_slave_adr", s_wb_adr, 32'h0);
      chk("rst_slave_datwr", s_wb_datwr, 32'h0);
      chk("rst_acks", {30'b0, m0_wb_ack, m1_wb_ack}, 32'd0);
      chk("rst_m0_datrd", m0_wb_datrd, 32'h0);
      tick();
      reset = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();

      // Single master read with two wait states
      rd_data = 32'hDEAD_BEEF;
      slave_wait = 2;
      push_s(32'h10, 32'h0, 4'hF, 1'b0);
      push_a(0, 32'hDEAD_BEEF, 1'b0);
      fork
         m_run(0, 1, 1'b0, 32'h10, 32'h0, 4'hF);
         begin
            @(negedge clock);
            chk("lat_stb_c0", {31'b0, s_wb_stb}, 32'd0);
            chk("lat_grant_c0", {30'b0, grant}, 32'd0);
            @(negedge clock);
            chk("lat_stb_c1", {31'b0, s_wb_stb}, 32'd1);
            chk("lat_grant_c1", {30'b0, grant}, 32'd1);
            chk("lat_adr_c1", s_wb_adr, 32'h10);
            chk("lat_m1_datrd", m1_wb_datrd, 32'h0);
         end
      join
      tick();

      // Simultaneous requests after reset: m0, m1, m0, m1
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      slave_wait = 0;
      rd_data = 32'h600D_CAFE;
      push_s(32'h100, 32'h1111_1111, 4'hF, 1'b1);
      push_s(32'h200, 32'h2222_2222, 4'h3, 1'b1);
      push_s(32'h180, 32'h3333_3333, 4'hF, 1'b1);
      push_s(32'h280, 32'h4444_4444, 4'hC, 1'b1);
      push_a(0, 32'h600D_CAFE, 1'b0);
      push_a(1, 32'h600D_CAFE, 1'b0);
      push_a(0, 32'h600D_CAFE, 1'b0);
      push_a(1, 32'h600D_CAFE, 1'b0);
      fork
         begin
            m_run(0, 1, 1'b1, 32'h100, 32'h1111_1111, 4'hF);
            m_run(0, 1, 1'b1, 32'h180, 32'h3333_3333, 4'hF);
         end
         begin
            m_run(1, 1, 1'b1, 32'h200, 32'h2222_2222, 4'h3);
            m_run(1, 1, 1'b1, 32'h280, 32'h4444_4444, 4'hC);
         end
      join
      tick();

      // Bus lock: m1 holds cyc for three writes while m0 waits
      slave_wait = 1;
      rd_data = 32'h5A5A_0001;
      push_s(32'h300, 32'hA000_0000, 4'h5, 1'b1);
      push_s(32'h304, 32'hA000_0001, 4'h5, 1'b1);
      push_s(32'h308, 32'hA000_0002, 4'h5, 1'b1);
      push_s(32'h400, 32'h0, 4'hF, 1'b0);
      push_a(1, 32'h5A5A_0001, 1'b0);
      push_a(1, 32'h5A5A_0001, 1'b0);
      push_a(1, 32'h5A5A_0001, 1'b0);
      push_a(0, 32'h5A5A_0001, 1'b0);
      fork
         m_run(1, 3, 1'b1, 32'h300, 32'hA000_0000, 4'h5);
         begin
            tick();
            m_run(0, 1, 1'b0, 32'h400, 32'h0, 4'hF);
         end
         begin
            int n;
            n = 0;
            @(negedge clock);
            while (m1_wb_cyc && n < 100) begin
               @(negedge clock);
               n++;
            end
            chk("lock_m1_released", {31'b0, m1_wb_cyc}, 32'd0);
            @(negedge clock);
            chk("lock_idle_grant", {30'b0, grant}, 32'd0);
            chk("lock_idle_stb", {31'b0, s_wb_stb}, 32'd0);
            @(negedge clock);
            chk("lock_m0_grant", {30'b0, grant}, 32'd1);
            chk("lock_m0_stb", {31'b0, s_wb_stb}, 32'd1);
            chk("lock_m0_adr", s_wb_adr, 32'h400);
         end
      join
      tick();

      // Watchdog: slave never acks
      slave_wait = -1;
      push_a(0, 32'hFFFF_FFFF, 1'b1);
      fork
         m_run(0, 1, 1'b0, 32'h500, 32'h0, 4'hF);
         begin
            int hit;
            int d2;
            hit = -1;
            d2 = 0;
            for (int i = 0; i < 8; i++) begin
               @(negedge clock);
               if (m0_wb_ack && hit < 0) hit = i;
               if (d2_m0_ack) d2++;
               if (i == 5) chk("nowd_stb_held", {31'b0, d2_s_stb}, 32'd1);
            end
            chk("wd_ack_cycle", 32'(hit), 32'd5);
            chk("nowd_no_ack", 32'(d2), 32'd0);
         end
      join
      tick();

      // Reset in the middle of an m1 transfer
      drive(1, 1'b1, 1'b1, 1'b0, 32'h600, 32'h77, 4'hF);
      tick();
      @(negedge clock);
      chk("rmid_grant_before", {30'b0, grant}, 32'd2);
      chk("rmid_stb_before", {31'b0, s_wb_stb}, 32'd1);
      reset = 1'b1;
      tick();
      @(negedge clock);
      chk("rmid_grant_after", {30'b0, grant}, 32'd0);
      chk("rmid_cyc_after", {31'b0, s_wb_cyc}, 32'd0);
      chk("rmid_m1_ack", {31'b0, m1_wb_ack}, 32'd0);
      tick();
      reset = 1'b0;
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      slave_wait = 0;
      rd_data = 32'h1357_9BDF;
      push_s(32'h700, 32'h0, 4'hF, 1'b0);
      push_s(32'h800, 32'h0, 4'hF, 1'b0);
      push_a(0, 32'h1357_9BDF, 1'b0);
      push_a(1, 32'h1357_9BDF, 1'b0);
      fork
         m_run(0, 1, 1'b0, 32'h700, 32'h0, 4'hF);
         m_run(1, 1, 1'b0, 32'h800, 32'h0, 4'hF);
      join
      tick();

      // Stray slave acks: in IDLE and while owned with stb low
      slave_en = 1'b0;
      s_wb_ack = 1'b1;
      @(negedge clock);
      chk("stray_idle_acks", {30'b0, m0_wb_ack, m1_wb_ack}, 32'd0);
      tick();
      s_wb_ack = 1'b0;
      drive(0, 1'b1, 1'b0, 1'b0, 32'h900, 32'h0, 4'hF);
      tick();
      s_wb_ack = 1'b1;
      @(negedge clock);
      chk("stray_own_grant", {30'b0, grant}, 32'd1);
      chk("stray_own_acks", {30'b0, m0_wb_ack, m1_wb_ack}, 32'd0);
      tick();
      s_wb_ack = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      slave_en = 1'b1;
      repeat (3) tick();

      chk("sb_slave_drained", 32'(sq.size()), 32'd0);
      chk("sb_ack_drained", 32'(aq.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
